// File: rtl/raster_to_block.sv
// Raster-to-8x8-block reorder buffer: ping-pong strips of 8 rows, read out as row-major 8x8 blocks.
// Optional LEVEL_SHIFT_EN macro: output p-128 instead of zero-extended p.
module raster_to_block #(
    parameter int IMG_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic signed [31:0] dout,
    output logic               dout_valid,
    input  logic               ds_ready,
    output logic               sob
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int AW = CW + 4;
    localparam int RW = CW + 3;
    localparam logic [RW-1:0] RD_LAST  = RW'(8 * IMG_W - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    logic [7:0] mem [0:(2**AW)-1];

    logic          wr_bank;
    logic [2:0]    wr_row;
    logic [CW-1:0] wr_col;
    logic [1:0]    full;

    logic          rd_bank;
    logic          iss_bank;
    logic [RW-1:0] rd_cnt;
    logic [CW-1:0] rd_col;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic [7:0]    rd_data;
    logic          s1_valid;
    logic          s1_sob;
    logic          s1_last;
    logic          out_last;
    logic signed [31:0] sample;

    logic wr_en;
    logic strip_done;
    logic advance;
    logic issue;
    logic release_bank;

    assign din_ready    = !rst && !full[wr_bank];
    assign wr_en        = din_valid && din_ready;
    assign strip_done   = wr_en && (wr_row == 3'd7) && (wr_col == COL_LAST);
    assign advance      = !dout_valid || ds_ready;
    assign issue        = advance && full[iss_bank];
    assign release_bank = dout_valid && ds_ready && out_last;

    // rd_cnt runs linearly over the bank as {block, row, col}; remap to strip column
    assign rd_col  = CW'({rd_cnt >> 6, rd_cnt[2:0]});
    assign wr_addr = {wr_bank, wr_row, wr_col};
    assign rd_addr = {iss_bank, rd_cnt[5:3], rd_col};

`ifdef LEVEL_SHIFT_EN
    assign sample = $signed({24'd0, rd_data}) - 32'sd128;
`else
    assign sample = $signed({24'd0, rd_data});
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= din;
        if (issue)
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_row  <= 3'd0;
            wr_col  <= '0;
        end else if (wr_en) begin
            if (wr_col == COL_LAST) begin
                wr_col <= '0;
                if (wr_row == 3'd7) begin
                    wr_row  <= 3'd0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 3'd1;
                end
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // Release and fill always target different banks, so both updates can land together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            rd_bank <= 1'b0;
        end else begin
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (strip_done)
                full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_bank <= 1'b0;
            rd_cnt   <= '0;
        end else if (issue) begin
            if (rd_cnt == RD_LAST) begin
                rd_cnt   <= '0;
                iss_bank <= ~iss_bank;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Two-stage read pipe (RAM register, output register) that moves only when the output frees up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sob     <= 1'b0;
            s1_last    <= 1'b0;
            dout_valid <= 1'b0;
            sob        <= 1'b0;
            out_last   <= 1'b0;
            dout       <= '0;
        end else if (advance) begin
            s1_valid   <= issue;
            s1_sob     <= issue && (rd_cnt[5:0] == 6'd0);
            s1_last    <= issue && (rd_cnt == RD_LAST);
            dout_valid <= s1_valid;
            sob        <= s1_valid && s1_sob;
            out_last   <= s1_valid && s1_last;
            if (s1_valid)
                dout <= sample;
        end
    end

endmodule
